branch_sequencer: RTL
=====================

Name: branch_sequencer

Overview:
- Multi-cycle controller that owns the branch comparison unit in the RV32I core.
- Accepts one control-transfer request (BRANCH/JAL/JALR) from decode and drives the comparison unit's operands and mode.
- Computes the target, checks alignment, then issues a PC redirect to fetch with a valid/ready handshake.
- Reports completion, link value and exceptions back to the control unit.

Parameters:
- XLEN, 32, datapath width; all operand, PC and counter widths use it.
- RESET_PC_ALIGN, 2, number of target LSBs that must be zero. The value 2 means IALIGN=32. The value 1 is allowed for a future C extension.

Ports:
- clk  in  1  rising-edge clock
- res_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_kind  in  2  00=BRANCH, 01=JAL, 10=JALR, 11=illegal
- req_funct3  in  3  branch condition; same encoding as the comparison codes
- req_pc  in  XLEN  PC of the instruction
- req_imm  in  XLEN  sign-extended offset
- req_rs1, req_rs2  in  XLEN  register operands
- cmp_in_0, cmp_in_1  out  XLEN  operands to the comparison unit
- cmp_mode  out  3  mode to the comparison unit
- cmp_branch  in  1  comparison result (combinational)
- redir_valid  out  1  redirect request to fetch
- redir_ready  in  1  fetch accepts the redirect
- redir_pc  out  XLEN  new PC
- done  out  1  one-cycle pulse: instruction retired
- done_taken  out  1  valid with done
- link_val  out  XLEN  req_pc+4, valid with done (rd writeback for JAL/JALR)
- exc_valid  out  1  one-cycle pulse: misaligned-target or illegal exception
- exc_cause  out  2  01=misaligned target, 10=illegal funct3/kind

Behaviour:
- Reset (res_n=0 at a clock edge): state IDLE. All outputs are 0 except req_ready=1. Internal registers are cleared.
- Reset mid-operation aborts the instruction with no done and no redirect.
- States: IDLE, CMP, RESOLVE, REDIR.
- IDLE:
  - On req_valid && req_ready, capture all req_* fields and go to CMP.
  - A request with kind 11, or BRANCH with funct3 010/011, still goes to CMP but is flagged illegal.
- CMP (1 cycle):
  - cmp_in_0=captured rs1, cmp_in_1=captured rs2, cmp_mode=captured funct3.
  - Register cmp_branch as taken for BRANCH. JAL/JALR are always taken and ignore cmp_branch.
  - In all other states cmp_in_0, cmp_in_1 and cmp_mode are 0.
  - Target is computed in modulo-2^XLEN arithmetic, wrap-around silent:
    - BRANCH/JAL: pc+imm
    - JALR: (rs1+imm) with bit0 cleared
  - link_val = pc+4, also wrapping.
  - Next state is RESOLVE.
- RESOLVE (1 cycle), checked in this priority order:
  - Illegal: exc_valid=1, exc_cause=10, then IDLE.
  - Taken and target[RESET_PC_ALIGN-1:0]!=0: exc_valid=1, exc_cause=01, then IDLE. No redirect, no done.
  - Not-taken branch: done=1, done_taken=0, then IDLE.
  - Otherwise: go to REDIR.
- REDIR:
  - redir_valid=1 and redir_pc is held stable until redir_ready.
  - On the handshake cycle: done=1, done_taken=1, link_val valid, then IDLE.
  - redir_ready while redir_valid=0 is ignored.
- Latency, request accept to completion:
  - Not-taken: 2 cycles.
  - Taken: 3 cycles minimum; each cycle of redir_ready low adds one.
- Throughput: at most one instruction in flight. req_ready=0 outside IDLE, so a request asserted in the completion cycle is accepted in the following IDLE cycle.
- done and exc_valid are never high in the same cycle.

Optional Feature:
- Macro: BRANCH_SEQ_PERF_EN
- Defined:
  - Adds outputs perf_branches (XLEN) and perf_taken (XLEN).
  - perf_branches counts every done for kind BRANCH; perf_taken counts those with done_taken=1.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20:
  - cmp_mode=000 in CMP.
  - redir_valid=1 with redir_pc=0x120 three cycles after accept (redir_ready=1).
  - done=1, done_taken=1, link_val=0x104.
- BLT, rs1=0xFFFFFFFF, rs2=1 -> taken (signed). BLTU with the same operands -> done=1 and done_taken=0 two cycles after accept, redir_valid never asserted.
- JALR, rs1=0x203, imm=0 -> redir_pc=0x202 triggers exc_valid=1 with exc_cause=01 (target misaligned, bit1 set). JALR with rs1=0x201 -> redir_pc=0x200, done_taken=1.
- JAL pc=0xFFFFFFFC, imm=8, redir_ready held low 4 cycles:
  - redir_pc=0x4, stable for 5 cycles, wrap-around honoured.
  - done pulses once, on the handshake cycle.
  - link_val=0x0.
- BRANCH with funct3=010 -> exc_valid=1, exc_cause=10, no done. Separately, res_n=0 asserted while in REDIR -> next cycle redir_valid=0, req_ready=1, and no done or exc_valid is emitted.
- With BRANCH_SEQ_PERF_EN defined: 3 taken BEQ plus 2 not-taken BNE -> perf_branches=5, perf_taken=3.

Source files
------------

// File: rtl/branch_sequencer.sv
// branch_sequencer: multi-cycle control-transfer sequencer for an RV32I core.
// Owns the branch comparison unit for one BRANCH/JAL/JALR at a time, computes
// and checks the target, and redirects fetch through a valid/ready handshake.
// Optional feature macro: BRANCH_SEQ_PERF_EN adds saturating branch counters
// (perf_branches, perf_taken).
module branch_sequencer #(
    parameter int XLEN           = 32,
    parameter int RESET_PC_ALIGN = 2
) (
    input  logic            clk,
    input  logic            res_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_kind,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_imm,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic [XLEN-1:0] cmp_in_0,
    output logic [XLEN-1:0] cmp_in_1,
    output logic [2:0]      cmp_mode,
    input  logic            cmp_branch,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            done,
    output logic            done_taken,
    output logic [XLEN-1:0] link_val,
    output logic            exc_valid,
    output logic [1:0]      exc_cause
`ifdef BRANCH_SEQ_PERF_EN
    ,
    output logic [XLEN-1:0] perf_branches,
    output logic [XLEN-1:0] perf_taken
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_CMP, ST_RESOLVE, ST_REDIR} state_t;

    localparam logic [1:0] KIND_BRANCH    = 2'b00;
    localparam logic [1:0] KIND_JALR      = 2'b10;
    localparam logic [1:0] KIND_ILLEGAL   = 2'b11;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;

    // Target LSBs that must be zero for a legal redirect.
    localparam logic [XLEN-1:0] ALIGN_MASK =
        {{(XLEN-RESET_PC_ALIGN){1'b0}}, {RESET_PC_ALIGN{1'b1}}};
    localparam logic [XLEN-1:0] CLEAR_BIT0 = ~{{(XLEN-1){1'b0}}, 1'b1};

    state_t            state;
    logic [1:0]        cap_kind;
    logic [XLEN-1:0]   cap_pc;
    logic [XLEN-1:0]   cap_imm;
    logic [XLEN-1:0]   cap_rs1;
    logic              cap_illegal;
    logic              go_redir;
    logic              done_resolve;

    logic [XLEN-1:0]   target;
    logic              taken_now;
    logic              misaligned;
    logic              handshake;

    assign req_ready  = (state == ST_IDLE);
    // A redirect accepted during reset is not a retirement.
    assign handshake  = redir_valid && redir_ready && res_n;
    assign done       = done_resolve || handshake;
    assign done_taken = handshake;

    // Target, taken decision and alignment check, all from captured fields.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        target     = cap_pc + cap_imm;
        taken_now  = 1'b1;
        if (cap_kind == KIND_JALR) begin
            target = (cap_rs1 + cap_imm) & CLEAR_BIT0;
        end
        if (cap_kind == KIND_BRANCH) begin
            taken_now = cmp_branch;
        end
        misaligned = (target & ALIGN_MASK) != '0;
    end

    // Control FSM with registered outputs; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state        <= ST_IDLE;
            cap_kind     <= '0;
            cap_pc       <= '0;
            cap_imm      <= '0;
            cap_rs1      <= '0;
            cap_illegal  <= 1'b0;
            go_redir     <= 1'b0;
            done_resolve <= 1'b0;
            cmp_in_0     <= '0;
            cmp_in_1     <= '0;
            cmp_mode     <= '0;
            redir_valid  <= 1'b0;
            redir_pc     <= '0;
            link_val     <= '0;
            exc_valid    <= 1'b0;
            exc_cause    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            done_resolve <= 1'b0;
            exc_valid    <= 1'b0;
            exc_cause    <= '0;
            cmp_in_0     <= '0;
            cmp_in_1     <= '0;
            cmp_mode     <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_kind    <= req_kind;
                        cap_pc      <= req_pc;
                        cap_imm     <= req_imm;
                        cap_rs1     <= req_rs1;
                        cap_illegal <= (req_kind == KIND_ILLEGAL) ||
                                       (req_kind == KIND_BRANCH && req_funct3[2:1] == 2'b01);
                        cmp_in_0    <= req_rs1;
                        cmp_in_1    <= req_rs2;
                        cmp_mode    <= req_funct3;
                        state       <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    redir_pc <= target;
                    link_val <= cap_pc + XLEN'(4);
                    go_redir <= 1'b0;
                    if (cap_illegal) begin
                        exc_valid <= 1'b1;
                        exc_cause <= CAUSE_ILLEGAL;
                    end else if (taken_now && misaligned) begin
                        exc_valid <= 1'b1;
                        exc_cause <= CAUSE_MISALIGN;
                    end else if (!taken_now) begin
                        done_resolve <= 1'b1;
                    end else begin
                        go_redir <= 1'b1;
                    end
                    state <= ST_RESOLVE;
                end
                ST_RESOLVE: begin
                    if (go_redir) begin
                        redir_valid <= 1'b1;
                        state       <= ST_REDIR;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_REDIR: begin
                    if (redir_ready) begin
                        redir_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BRANCH_SEQ_PERF_EN
    // Saturating retirement counters for conditional branches.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            perf_branches <= '0;
            perf_taken    <= '0;
        end else if (done && cap_kind == KIND_BRANCH) begin
            if (perf_branches != '1) perf_branches <= perf_branches + XLEN'(1);
            if (done_taken && perf_taken != '1) perf_taken <= perf_taken + XLEN'(1);
        end
    end
`endif

endmodule
